// File: rtl/ps2_key_decoder_if.sv
// Pin and result bundle between the PS/2 keyboard decoder and its consumers.
// The decoder attaches to the slave modport. The keyboard side, or a bench, attaches to the master modport.
interface ps2_key_decoder_if;
    // scan_valid is a one-cycle strobe and scan_code is meaningful only while it is high.
    // There is no ready signal, so a consumer that misses the strobe loses that byte.
    // frame_err is a separate one-cycle strobe and is never high together with scan_valid.
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_space;
    logic       key_left;
    logic       key_right;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;
    logic [1:0] frame_state;
    logic [1:0] decode_state;

    modport master (
        output ps2_clk, ps2_data,
        input  key_space, key_left, key_right, scan_code, scan_valid, frame_err,
        input  frame_state, decode_state
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output key_space, key_left, key_right, scan_code, scan_valid, frame_err,
        output frame_state, decode_state
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 frame receiver and make/break decoder for Space, Left and Right, producing held-key levels.
// Defining PS2_PARITY_CHECK_EN makes the receiver reject frames whose parity is not odd.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input logic              clk,
    input logic              rst,
    ps2_key_decoder_if.slave bus
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} frame_state_t;
    typedef enum logic [1:0] {BASE, EXT, BRK, EXT_BRK} decode_state_t;

    logic [1:0]     clk_sync, data_sync;
    logic           filt, filt_d, bit_event;
    logic [FCW-1:0] filt_cnt;

    // The filtered clock is the only clock-like signal used below. bit_event is its registered falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt      <= 1'b1;
            filt_d    <= 1'b1;
            filt_cnt  <= '0;
            bit_event <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            data_sync <= {data_sync[0], bus.ps2_data};
            filt_d    <= filt;
            bit_event <= filt_d & ~filt;
            if (clk_sync[1] == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                filt     <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    frame_state_t   fstate, fstate_nx;
    logic [3:0]     bit_cnt, bit_cnt_nx;
    logic [8:0]     shreg, shreg_nx;
    logic [TCW-1:0] tcnt;
    logic           data_s, timed_out, parity_ok, accept_nx, reject_nx;
    logic [7:0]     scan_code_r;
    logic           scan_valid_r, frame_err_r;

    assign data_s = data_sync[1];

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^shreg;
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        fstate_nx  = fstate;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        accept_nx  = 1'b0;
        reject_nx  = 1'b0;
        timed_out  = (fstate != IDLE) && !bit_event && (tcnt == TCW'(TIMEOUT_CYCLES - 1));
        if (timed_out) begin
            fstate_nx = IDLE;
            reject_nx = 1'b1;
        end else if (bit_event) begin
            case (fstate)
                IDLE: begin
                    if (!data_s) begin
                        fstate_nx  = RECV;
                        bit_cnt_nx = 4'd0;
                    end
                end
                // Nine shifts, LSB first, leave the data in shreg[7:0] and the parity bit in shreg[8].
                RECV: begin
                    shreg_nx = {data_s, shreg[8:1]};
                    if (bit_cnt == 4'd8) fstate_nx = CHECK;
                    else bit_cnt_nx = bit_cnt + 4'd1;
                end
                CHECK: begin
                    fstate_nx = IDLE;
                    if (data_s && parity_ok) accept_nx = 1'b1;
                    else reject_nx = 1'b1;
                end
                default: fstate_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fstate       <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            tcnt         <= '0;
            scan_code_r  <= 8'h00;
            scan_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            fstate       <= fstate_nx;
            bit_cnt      <= bit_cnt_nx;
            shreg        <= shreg_nx;
            scan_valid_r <= accept_nx;
            frame_err_r  <= reject_nx;
            if (accept_nx) scan_code_r <= shreg[7:0];
            if (fstate == IDLE || bit_event) tcnt <= '0;
            else if (tcnt != TCW'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;
        end
    end

    decode_state_t dstate, dstate_nx;
    logic          space_r, left_r, right_r, space_nx, left_nx, right_nx;

    always_comb begin
        dstate_nx = dstate;
        space_nx  = space_r;
        left_nx   = left_r;
        right_nx  = right_r;
        if (scan_valid_r) begin
            case (dstate)
                BASE: begin
                    if (scan_code_r == 8'hE0) dstate_nx = EXT;
                    else if (scan_code_r == 8'hF0) dstate_nx = BRK;
                    else if (scan_code_r == 8'h29) space_nx = 1'b1;
                end
                EXT: begin
                    dstate_nx = (scan_code_r == 8'hF0) ? EXT_BRK : BASE;
                    if (scan_code_r == 8'h6B) left_nx = 1'b1;
                    if (scan_code_r == 8'h74) right_nx = 1'b1;
                end
                BRK: begin
                    dstate_nx = BASE;
                    if (scan_code_r == 8'h29) space_nx = 1'b0;
                end
                EXT_BRK: begin
                    dstate_nx = BASE;
                    if (scan_code_r == 8'h6B) left_nx = 1'b0;
                    if (scan_code_r == 8'h74) right_nx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dstate  <= BASE;
            space_r <= 1'b0;
            left_r  <= 1'b0;
            right_r <= 1'b0;
        end else begin
            dstate  <= dstate_nx;
            space_r <= space_nx;
            left_r  <= left_nx;
            right_r <= right_nx;
        end
    end

    assign bus.key_space    = space_r;
    assign bus.key_left     = left_r;
    assign bus.key_right    = right_r;
    assign bus.scan_code    = scan_code_r;
    assign bus.scan_valid   = scan_valid_r;
    assign bus.frame_err    = frame_err_r;
    assign bus.frame_state  = fstate;
    assign bus.decode_state = dstate;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: a directed vector table, hand-written corner sequences and random frames.
// Random frames are checked against a sequence-level model of the scan-code rules.
module tb_ps2_key_decoder;
    localparam int FL = 8;
    localparam int TO = 500;
    localparam int H  = 16;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    ps2_key_decoder_if bus();

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of held keys: bytes collect into a sequence until it forms a complete code.
    bit         m_space, m_left, m_right;
    logic [7:0] m_seq[$];

    function automatic void model_byte(input logic [7:0] b);
        bit ext, brk;
        logic [7:0] code;
        m_seq.push_back(b);
        if (m_seq.size() == 1 && (b == 8'hE0 || b == 8'hF0)) return;
        if (m_seq.size() == 2 && m_seq[0] == 8'hE0 && b == 8'hF0) return;
        ext  = (m_seq[0] == 8'hE0);
        brk  = (m_seq.size() > 1) && (m_seq[m_seq.size() - 2] == 8'hF0);
        code = b;
        if (!ext && code == 8'h29) m_space = !brk;
        if (ext && code == 8'h6B) m_left = !brk;
        if (ext && code == 8'h74) m_right = !brk;
        m_seq.delete();
    endfunction

    // Scoreboard and monitor.
    logic [7:0] exp_q[$];
    int sv_seen = 0, err_seen = 0, exp_err = 0;
    int stop_k0 = 0, to_k0 = 0;
    bit stop_pending = 0, to_pending = 0;
    bit key_chk_next = 0, prev_sv = 0, prev_err = 0;

    always @(negedge clk) begin
        if (key_chk_next) begin
            check("key_space_after", bus.key_space, m_space);
            check("key_left_after", bus.key_left, m_left);
            check("key_right_after", bus.key_right, m_right);
            key_chk_next = 0;
        end
        if (bus.scan_valid) begin
            sv_seen++;
            check("valid_err_overlap", bus.frame_err, 1'b0);
            check("valid_width", prev_sv, 1'b0);
            if (stop_pending) check("valid_latency", cyc - stop_k0, FL + 3);
            stop_pending = 0;
            check("scan_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("scan_code", bus.scan_code, e);
                check("keys_before", {bus.key_space, bus.key_left, bus.key_right},
                      {m_space, m_left, m_right});
                model_byte(e);
                key_chk_next = 1;
            end
        end
        if (bus.frame_err) begin
            err_seen++;
            check("err_width", prev_err, 1'b0);
            if (stop_pending) check("err_latency", cyc - stop_k0, FL + 3);
            else if (to_pending) check("timeout_latency", cyc - to_k0, FL + 3 + TO);
            stop_pending = 0;
            to_pending = 0;
        end
        prev_sv  = bus.scan_valid;
        prev_err = bus.frame_err;
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        m_space = 0;
        m_left  = 0;
        m_right = 0;
        m_seq.delete();
        exp_q.delete();
        stop_pending = 0;
        to_pending   = 0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            repeat (H / 2) @(negedge clk);
            bus.ps2_data = bits[i];
            repeat (H / 2) @(negedge clk);
            bus.ps2_clk = 1'b0;
            if (i == 10) begin
                stop_k0 = cyc + 1;
                stop_pending = 1;
            end
            if (nbits < 11 && i == nbits - 1) begin
                to_k0 = cyc + 1;
                to_pending = 1;
            end
            repeat (H) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        repeat (3 * H) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        if (!bad_stop && !(bad_par && PAR_EN)) exp_q.push_back(d);
        else exp_err++;
        send_frame(d, bad_par, bad_stop, 11);
        check("err_count", err_seen, exp_err);
        check("scan_drained", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [7:0] b;
        bit bad_par;
        bit bad_stop;
        bit e_space;
        bit e_left;
        bit e_right;
    } vec_t;

    vec_t vecs[22];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sv0, err0;
        vecs[0]  = '{8'h29, 0, 0, 1, 0, 0};
        vecs[1]  = '{8'hE0, 0, 0, 1, 0, 0};
        vecs[2]  = '{8'h74, 0, 0, 1, 0, 1};
        vecs[3]  = '{8'hE0, 0, 0, 1, 0, 1};
        vecs[4]  = '{8'hF0, 0, 0, 1, 0, 1};
        vecs[5]  = '{8'h74, 0, 0, 1, 0, 0};
        vecs[6]  = '{8'hE0, 0, 0, 1, 0, 0};
        vecs[7]  = '{8'h6B, 0, 0, 1, 1, 0};
        vecs[8]  = '{8'hE0, 0, 0, 1, 1, 0};
        vecs[9]  = '{8'h74, 0, 0, 1, 1, 1};
        vecs[10] = '{8'h74, 0, 0, 1, 1, 1};
        vecs[11] = '{8'h29, 0, 0, 1, 1, 1};
        vecs[12] = '{8'hF0, 0, 0, 1, 1, 1};
        vecs[13] = '{8'h29, 0, 0, 0, 1, 1};
        vecs[14] = '{8'h29, 1, 0, !PAR_EN, 1, 1};
        vecs[15] = '{8'hF0, 0, 1, !PAR_EN, 1, 1};
        vecs[16] = '{8'hF0, 0, 0, !PAR_EN, 1, 1};
        vecs[17] = '{8'h29, 0, 0, 0, 1, 1};
        vecs[18] = '{8'hAA, 0, 0, 0, 1, 1};
        vecs[19] = '{8'hE0, 0, 0, 0, 1, 1};
        vecs[20] = '{8'hF0, 0, 0, 0, 1, 1};
        vecs[21] = '{8'h6B, 0, 0, 0, 0, 1};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        do_reset(3);
        check("rst_key_space", bus.key_space, 1'b0);
        check("rst_key_left", bus.key_left, 1'b0);
        check("rst_key_right", bus.key_right, 1'b0);
        check("rst_scan_code", bus.scan_code, 8'h00);
        check("rst_scan_valid", bus.scan_valid, 1'b0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        check("rst_frame_state", bus.frame_state, 2'd0);
        check("rst_decode_state", bus.decode_state, 2'd0);

        for (int i = 0; i < 22; i++) begin
            frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop);
            check("vec_space", bus.key_space, vecs[i].e_space);
            check("vec_left", bus.key_left, vecs[i].e_left);
            check("vec_right", bus.key_right, vecs[i].e_right);
            if (i == 5) check("right_seq_base", bus.decode_state, 2'd0);
        end

        // A glitch on ps2_clk that is shorter than the filter must produce no bit event.
        sv0  = sv_seen;
        err0 = err_seen;
        @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_valid", sv_seen, sv0);
        check("glitch_no_err", err_seen, err0);
        check("glitch_idle", bus.frame_state, 2'd0);

        // A frame that stalls after four data bits must time out, and the next frame must decode.
        exp_err++;
        send_frame(8'h29, 0, 0, 5);
        repeat (TO + 10) @(negedge clk);
        check("timeout_err", err_seen, exp_err);
        check("timeout_idle", bus.frame_state, 2'd0);
        frame(8'h29, 0, 0);
        check("after_timeout_space", bus.key_space, 1'b1);

        // Reset in the middle of a frame, while keys are held.
        frame(8'hE0, 0, 0);
        frame(8'h6B, 0, 0);
        check("hold_left", bus.key_left, 1'b1);
        check("hold_space", bus.key_space, 1'b1);
        send_frame(8'h74, 0, 0, 5);
        do_reset(1);
        check("midrst_space", bus.key_space, 1'b0);
        check("midrst_left", bus.key_left, 1'b0);
        check("midrst_right", bus.key_right, 1'b0);
        frame(8'hE0, 0, 0);
        frame(8'h6B, 0, 0);
        check("post_rst_left", bus.key_left, 1'b1);
        check("post_rst_space", bus.key_space, 1'b0);
        check("post_rst_right", bus.key_right, 1'b0);

        // Random frames checked against the model.
        do_reset(2);
        for (int n = 0; n < 60; n++) begin
            logic [7:0] d;
            bit bp, bs;
            case ($urandom_range(0, 9))
                0, 1:    d = 8'hE0;
                2:       d = 8'hF0;
                3:       d = 8'h29;
                4:       d = 8'h6B;
                5:       d = 8'h74;
                6:       d = 8'hAA;
                7:       d = 8'hFA;
                default: d = 8'($urandom_range(0, 255));
            endcase
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 19) == 0);
            frame(d, bp, bs);
            check("rand_keys", {bus.key_space, bus.key_left, bus.key_right},
                  {m_space, m_left, m_right});
        end

        check("final_scan_q", exp_q.size(), 0);
        check("final_err_count", err_seen, exp_err);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and decodes make/break scan codes into held-key levels. It drives `key_space`, `key_left` and `key_right` into the character movement controller. The block sits between the keyboard pins and that controller in the 100 MHz system domain. It also exposes each received byte and a frame-error pulse for debug and LEDs.

## Interface
- `FILTER_LEN`, 8: consecutive equal synchronized samples required before the filtered `ps2_clk` changes.
- `TIMEOUT_CYCLES`, 100_000: idle clocks (1 ms at 100 MHz) after which a partial frame is aborted.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: synchronous reset, active-high.
- `ps2_clk` in 1: raw keyboard clock, asynchronous.
- `ps2_data` in 1: raw keyboard data, asynchronous.
- `key_space` out 1: high while Space (0x29) is held.
- `key_left` out 1: high while Left arrow (E0 6B) is held.
- `key_right` out 1: high while Right arrow (E0 74) is held.
- `scan_code` out 8: last correctly received byte.
- `scan_valid` out 1: one-cycle pulse when `scan_code` updates.
- `frame_err` out 1: one-cycle pulse when a frame is rejected.

## Operation
- **Input conditioning**
  - Each raw input passes through a 2-FF synchronizer.
  - A glitch filter on the synchronized clock changes the filtered level only after `FILTER_LEN` consecutive samples at the new level.
  - A falling edge of the filtered clock is the bit event.
- **Frame FSM**, states `IDLE`, `RECV`, `CHECK`:
  - In `IDLE`, a bit event with data 0 (start bit) moves to `RECV` with the bit counter at 0. A bit event with data 1 is ignored.
  - In `RECV`, 8 data bits are shifted in LSB first, then the parity bit is captured. The FSM then goes to `CHECK`.
  - In `CHECK`, the next bit event samples the stop bit. Stop bit = 1 accepts the byte (subject to the parity rule below); stop bit = 0 rejects the frame. Either way the FSM returns to `IDLE`.
- **Timeout**
  - A counter runs in any state other than `IDLE` and clears on every bit event.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to `IDLE`, the partial byte is discarded and `frame_err` pulses.
- **Accepted byte:** `scan_code` loads the byte and `scan_valid` pulses.
- **Rejected frame:** `frame_err` pulses; `scan_code`, `scan_valid` and the decode FSM are unchanged.
- **Decode FSM**, states `BASE`, `EXT`, `BRK`, `EXT_BRK`. It advances only on `scan_valid`.
  - `BASE`:
    - E0 → `EXT`; F0 → `BRK`.
    - 29 sets `key_space`.
    - Any other byte (including AA, FA) is ignored and the FSM stays in `BASE`.
  - `EXT`:
    - F0 → `EXT_BRK`.
    - 6B sets `key_left`; 74 sets `key_right`.
    - Any byte other than F0 returns to `BASE`.
  - `BRK`: 29 clears `key_space`; any byte returns to `BASE`.
  - `EXT_BRK`: 6B clears `key_left`; 74 clears `key_right`; any byte returns to `BASE`.
- Typematic repeat make codes are idempotent: the key stays 1.
- Simultaneous holds are independent. Left and right may both be 1; priority belongs to the consumer.
- **Reset values:** all outputs 0, `scan_code` = 8'h00, both FSMs reset (frame FSM `IDLE`, decode FSM `BASE`), filter level 1, counters 0.
- Reset asserted mid-frame or mid-sequence discards everything; the next frame decodes cleanly.

## Timing
- Latency is counted from the first `clk` edge that samples `ps2_clk` low for the stop-bit edge.
  - `scan_valid` / `frame_err` assert exactly `FILTER_LEN+3` cycles later.
  - The `key_*` change exactly `FILTER_LEN+4` cycles later, i.e. one cycle after `scan_valid`.
- Data is sampled from the synchronized `ps2_data` on the bit-event cycle. PS/2 data is stable for at least 5 µs around the clock edge, which covers the delay.
- `scan_valid` and `frame_err` are never high in the same cycle and never high for more than 1 cycle.
- Timeout: `frame_err` pulses `TIMEOUT_CYCLES` cycles after the last bit event of a partial frame.
- The timeout counter is sized `$clog2(TIMEOUT_CYCLES+1)` and does not wrap.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - Odd parity over data+parity is checked in `CHECK`.
  - On mismatch the frame is rejected (`frame_err`), even with a valid stop bit.
- Not defined:
  - The parity bit is captured but ignored.
  - Only the stop bit (and the timeout) can cause `frame_err`.

## Test plan
- **Space make:** frame 0x29, correct parity, 10 µs bit period → `scan_code`=29 with `scan_valid` at `FILTER_LEN+3`; `key_space`=1 one cycle later; left and right stay 0.
- **Right arrow make/break:** E0 74, then E0 F0 74 → `key_right` rises after the second byte and falls after the fifth byte; `key_left` stays 0; decode FSM ends in `BASE`.
- **Bad parity:** 0x29 with even parity →
  - with `PS2_PARITY_CHECK_EN`: one `frame_err` pulse, no `scan_valid`, `key_space` stays 0;
  - without it: `key_space`=1.
- **Stalled frame:** start bit plus 4 data bits, then idle `TIMEOUT_CYCLES+10` cycles → one `frame_err` pulse. A following valid 0x29 frame sets `key_space`=1.
- **Clock glitch:** `ps2_clk` low for 3 cycles (< `FILTER_LEN`) while idle → no bit event, no `scan_valid`, no `frame_err`.
- **Reset mid-frame:** hold left+space, then assert `rst` for 1 cycle after the 5th bit of the next frame → all `key_*`=0 the cycle after `rst`. A subsequent E0 6B sets only `key_left`.
